// File: rtl/pipe_divider.sv
// Fully pipelined restoring divider: one quotient bit per stage, signed/unsigned per operation,
// divide-by-zero and overflow flags, tag passthrough, valid/ready backpressure with whole-pipe stall.
module pipe_divider #(
    parameter int unsigned XWIDTH = 8,
    parameter int unsigned DWIDTH = 3,
    parameter int unsigned TAGW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [XWIDTH-1:0] dividend,
    input  logic [DWIDTH-1:0] divisor,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XWIDTH-1:0] quotient,
    output logic [DWIDTH-1:0] remainder,
    output logic              div_zero,
    output logic              overflow,
    output logic [TAGW-1:0]   out_tag
);

    // Register 0 captures the front end; registers 1..XWIDTH each hold the result of one restoring step.
    localparam int unsigned NSTG = XWIDTH + 1;
    localparam int unsigned LAST = XWIDTH;

    logic              adv;
    logic [XWIDTH-1:0] fe_xmag;
    logic [DWIDTH-1:0] fe_dmag;
    logic              fe_qneg, fe_rneg, fe_dz, fe_ov;

    logic [NSTG-1:0]   vld_q, vld_d;
    logic [NSTG-1:0]   qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, ov_q, ov_d;
    logic [DWIDTH-1:0] rem_q  [NSTG];
    logic [DWIDTH-1:0] rem_d  [NSTG];
    logic [DWIDTH-1:0] dmag_q [NSTG];
    logic [DWIDTH-1:0] dmag_d [NSTG];
    logic [DWIDTH-1:0] xlow_q [NSTG];
    logic [DWIDTH-1:0] xlow_d [NSTG];
    logic [XWIDTH-1:0] xsh_q  [NSTG];
    logic [XWIDTH-1:0] xsh_d  [NSTG];
    logic [XWIDTH-1:0] quo_q  [NSTG];
    logic [XWIDTH-1:0] quo_d  [NSTG];
    logic [TAGW-1:0]   tag_q  [NSTG];
    logic [TAGW-1:0]   tag_d  [NSTG];
    logic [DWIDTH:0]   part   [XWIDTH];
    logic [XWIDTH-1:0] take;

    // Any held result freezes every stage, bubbles included.
    assign adv       = !vld_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];

    // Front end: magnitudes and sign/flag bookkeeping.
    always_comb begin
        fe_xmag = (in_signed && dividend[XWIDTH-1]) ? -dividend : dividend;
        fe_dmag = (in_signed && divisor[DWIDTH-1]) ? -divisor : divisor;
        fe_qneg = in_signed && (dividend[XWIDTH-1] ^ divisor[DWIDTH-1]);
        fe_rneg = in_signed && dividend[XWIDTH-1];
        fe_dz   = (divisor == '0);
        fe_ov   = in_signed && (dividend == {1'b1, {(XWIDTH-1){1'b0}}}) && (divisor == '1);
    end

    always_comb begin
        vld_d  = {vld_q[NSTG-2:0], in_valid};
        qneg_d = {qneg_q[NSTG-2:0], fe_qneg};
        rneg_d = {rneg_q[NSTG-2:0], fe_rneg};
        dz_d   = {dz_q[NSTG-2:0], fe_dz};
        ov_d   = {ov_q[NSTG-2:0], fe_ov};
        rem_d[0]  = '0;
        dmag_d[0] = fe_dmag;
        xlow_d[0] = dividend[DWIDTH-1:0];
        xsh_d[0]  = fe_xmag;
        quo_d[0]  = '0;
        tag_d[0]  = in_tag;
        // Restoring step, MSB first; the guard bit in part keeps the compare exact.
        for (int k = 0; k < XWIDTH; k++) begin
            part[k]     = {rem_q[k], xsh_q[k][XWIDTH-1]};
            take[k]     = (part[k] >= {1'b0, dmag_q[k]});
            rem_d[k+1]  = take[k] ? DWIDTH'(part[k] - {1'b0, dmag_q[k]}) : part[k][DWIDTH-1:0];
            dmag_d[k+1] = dmag_q[k];
            xlow_d[k+1] = xlow_q[k];
            xsh_d[k+1]  = xsh_q[k] << 1;
            quo_d[k+1]  = {quo_q[k][XWIDTH-2:0], take[k]};
            tag_d[k+1]  = tag_q[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            ov_q   <= ov_d;
            rem_q  <= rem_d;
            dmag_q <= dmag_d;
            xlow_q <= xlow_d;
            xsh_q  <= xsh_d;
            quo_q  <= quo_d;
            tag_q  <= tag_d;
        end
    end

    // Output fix-up; data reads zero whenever no result is presented (including during reset).
    always_comb begin
        quotient  = '0;
        remainder = '0;
        div_zero  = 1'b0;
        overflow  = 1'b0;
        out_tag   = '0;
        if (vld_q[LAST]) begin
            out_tag = tag_q[LAST];
            if (dz_q[LAST]) begin
                quotient  = '1;
                remainder = xlow_q[LAST];
                div_zero  = 1'b1;
            end else if (ov_q[LAST]) begin
                quotient  = {1'b1, {(XWIDTH-1){1'b0}}};
                overflow  = 1'b1;
            end else begin
                quotient  = qneg_q[LAST] ? -quo_q[LAST] : quo_q[LAST];
                remainder = rneg_q[LAST] ? -rem_q[LAST] : rem_q[LAST];
            end
        end
    end

endmodule

// File: tb/tb_pipe_divider.sv
// Randomized bench for pipe_divider against an arithmetic reference model with an in-order scoreboard.
module tb_pipe_divider;

    localparam int unsigned XW = 8;
    localparam int unsigned DW = 3;
    localparam int unsigned TW = 4;
    localparam int unsigned OW = 1 + XW + DW + 1 + 1 + TW;

    logic          clk, reset, in_valid, in_ready, in_signed, out_valid, out_ready, div_zero, overflow;
    logic [XW-1:0] dividend, quotient;
    logic [DW-1:0] divisor, remainder;
    logic [TW-1:0] in_tag, out_tag;

    typedef struct {
        logic [XW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        logic          ov;
        logic [TW-1:0] tag;
        int            acc;
        int            s0;
        bit            seen;
    } exp_t;

    exp_t          sb[$];
    int            n_tests, n_fail, cyc, stall_total;
    bit            hold_prev;
    logic [OW-1:0] snap;

    pipe_divider #(.XWIDTH(XW), .DWIDTH(DW), .TAGW(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .dividend(dividend), .divisor(divisor), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .div_zero(div_zero),
        .overflow(overflow), .out_tag(out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] obs();
        return {out_valid, quotient, remainder, div_zero, overflow, out_tag};
    endfunction

    // Reference: truncating division from plain integer arithmetic.
    function automatic exp_t model(input bit sg, input logic [XW-1:0] x, input logic [DW-1:0] d,
                                   input logic [TW-1:0] tg);
        exp_t e;
        int   sx, sd, qi, ri;
        e.tag = tg; e.dz = 1'b0; e.ov = 1'b0; e.acc = 0; e.s0 = 0; e.seen = 1'b0;
        if (d == '0) begin
            e.dz = 1'b1;
            e.q  = '1;
            e.r  = x[DW-1:0];
        end else begin
            if (sg) begin
                sx = int'($signed(x));
                sd = int'($signed(d));
            end else begin
                sx = int'(x);
                sd = int'(d);
            end
            qi   = sx / sd;
            ri   = sx % sd;
            e.q  = XW'(qi);
            e.r  = DW'(ri);
            e.ov = sg && (sx == -(2 ** (XW - 1))) && (sd == -1);
        end
        return e;
    endfunction

    // One clock: observe at the negedge, drive, predict the handshake, advance to the next negedge.
    task automatic tick(input bit iv, input bit sg, input logic [XW-1:0] x, input logic [DW-1:0] d,
                        input logic [TW-1:0] tg, input bit ordy, output bit acc);
        logic [OW-1:0] cur;
        exp_t          e;
        cur = obs();
        if (hold_prev) check_val("frozen", 32'(cur), 32'(snap));
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 32'(out_valid), 32'(0));
            end else if (!sb[0].seen) begin
                sb[0].seen = 1'b1;
                check_val("latency", 32'(cyc - 1 - sb[0].acc), 32'(XW + stall_total - sb[0].s0));
            end
        end
        in_valid = iv; in_signed = sg; dividend = x; divisor = d; in_tag = tg; out_ready = ordy;
        #1;
        check_val("in_ready", 32'(in_ready), 32'(!out_valid || ordy));
        acc = iv && in_ready;
        if (out_valid && ordy && sb.size() > 0) begin
            e = sb.pop_front();
            check_val("quotient", 32'(quotient), 32'(e.q));
            check_val("remainder", 32'(remainder), 32'(e.r));
            check_val("div_zero", 32'(div_zero), 32'(e.dz));
            check_val("overflow", 32'(overflow), 32'(e.ov));
            check_val("out_tag", 32'(out_tag), 32'(e.tag));
        end
        hold_prev = out_valid && !ordy;
        snap      = cur;
        if (!in_ready) stall_total++;
        if (acc) begin
            e     = model(sg, x, d, tg);
            e.acc = cyc;
            e.s0  = stall_total;
            sb.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        bit a;
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
            n++;
        end
        check_val("drained", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        bit            a, ordy;
        int            left, stall_left;
        bit            ps;
        logic [XW-1:0] px;
        logic [DW-1:0] pd;
        logic [TW-1:0] pt;

        n_tests = 0; n_fail = 0; cyc = 0; stall_total = 0; hold_prev = 1'b0; snap = '0;
        reset = 1'b1; in_valid = 1'b0; in_signed = 1'b0; dividend = '0; divisor = '0;
        in_tag = '0; out_ready = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("reset_outs", 32'(obs()), 32'(0));
        reset = 1'b1;

        // Directed values, including divide-by-zero and signed overflow.
        tick(1'b1, 1'b0, XW'(200), DW'(3), TW'(5), 1'b1, a);
        tick(1'b1, 1'b0, XW'(255), DW'(1), TW'(6), 1'b1, a);
        tick(1'b1, 1'b1, 8'hF9, 3'b010, TW'(7), 1'b1, a);
        tick(1'b1, 1'b1, 8'h07, 3'b100, TW'(8), 1'b1, a);
        tick(1'b1, 1'b0, XW'(100), DW'(0), TW'(9), 1'b1, a);
        tick(1'b1, 1'b1, 8'h80, 3'b111, TW'(10), 1'b1, a);
        tick(1'b1, 1'b1, 8'h80, 3'b000, TW'(11), 1'b1, a);
        tick(1'b1, 1'b0, 8'h80, 3'b111, TW'(12), 1'b1, a);
        drain(40);

        // Twelve back-to-back operations with a five-cycle consumer stall.
        left = 12; stall_left = 5;
        ps = 1'($urandom); px = XW'($urandom); pd = DW'($urandom); pt = TW'(0);
        for (int i = 0; i < 300 && (left > 0 || sb.size() > 0); i++) begin
            ordy = 1'b1;
            if (out_valid && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            tick(left > 0, ps, px, pd, pt, ordy, a);
            if (a) begin
                left--;
                ps = 1'($urandom); px = XW'($urandom); pd = DW'($urandom); pt = TW'(12 - left);
            end
        end
        check_val("bp_complete", 32'(left + sb.size()), 32'(0));

        // Alternating bubbles with random consumer readiness.
        for (int i = 0; i < 60; i++) begin
            tick(i % 2 == 0, 1'($urandom), XW'($urandom), DW'($urandom), TW'($urandom),
                 $urandom_range(0, 3) != 0, a);
        end
        drain(200);

        // Reset with six operations in flight; none may ever emerge.
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'($urandom), XW'($urandom), DW'($urandom), TW'(i), 1'b1, a);
        end
        check_val("inflight", 32'(sb.size()), 32'(6));
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check_val("rst_mid_outs", 32'(obs()), 32'(0));
        sb.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        tick(1'b1, 1'b0, XW'(200), DW'(3), TW'(13), 1'b1, a);
        drain(40);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0, '0, '0, 1'b1, a);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_divider.md
Name: pipe_divider

Overview:
- Parametrised, fully pipelined restoring divider; one quotient bit resolved per stage.
- Accepts one operation per cycle and returns quotient and remainder after a fixed latency of XWIDTH cycles.
- Adds a per-transaction signed mode, divide-by-zero and overflow flags, a tag passthrough, and valid/ready backpressure.
- Sits between operand producers and consumers in datapath blocks that need throughput-1 division.

Parameters:
- XWIDTH, 8, dividend and quotient width; number of pipeline stages.
- DWIDTH, 3, divisor and remainder width; must satisfy 2 <= DWIDTH <= XWIDTH.
- TAGW, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, operation offered.
- in_ready, output, 1, operation accepted when in_valid && in_ready.
- in_signed, input, 1, 1 = operands are two's complement; 0 = unsigned.
- dividend, input, XWIDTH, dividend X.
- divisor, input, DWIDTH, divisor D.
- in_tag, input, TAGW, opaque tag.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result when out_valid && out_ready.
- quotient, output, XWIDTH, Q.
- remainder, output, DWIDTH, R.
- div_zero, output, 1, D was 0.
- overflow, output, 1, signed most-negative / -1.
- out_tag, output, TAGW, tag of the result.

Behaviour:
- Reset (reset=0, asynchronous): every stage valid bit clears; out_valid=0. quotient, remainder, flags and out_tag read 0 while reset is asserted. Data registers need no reset. Operations in flight when reset asserts are discarded, never emitted.
- Pipeline enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - When adv=1, all stages shift one step.
  - When adv=0, every stage holds, including invalid bubbles; the pipeline does not compress.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+XWIDTH, given no stalls. Each stall cycle adds exactly one cycle. Throughput is 1 per cycle.
- Front end (combinational, before stage 0):
  - If in_signed, take magnitudes |X| (XWIDTH-bit unsigned) and |D| (DWIDTH-bit unsigned; |-2^(DWIDTH-1)| fits).
  - Record qneg = sign(X) xor sign(D) and rneg = sign(X).
  - Record dz = (D==0) and ov = in_signed && X==100..0 && D==all-ones.
- Stage k (k = 0..XWIDTH-1), restoring step, MSB first:
  - partial = {rem, next dividend bit}.
  - If partial >= |D|, then q bit = 1 and rem = partial - |D|; otherwise q bit = 0 and rem = partial.
  - rem is DWIDTH bits plus one guard bit internally.
  - |D|, remaining dividend bits, the partial quotient, sign/flag bits and the tag travel with each stage.
- Output fix-up (combinational after the last register):
  - Normal: quotient = qneg ? -Qmag : Qmag; remainder = rneg ? -Rmag : Rmag, truncated to DWIDTH. R always has the sign of X and |R| < |D|.
  - div_zero=1: quotient = all ones; remainder = X[DWIDTH-1:0]; overflow=0. This applies in both modes, with no sign fix-up.
  - overflow=1: quotient = 100..0 (wrapped -2^(XWIDTH-1)); remainder = 0.
  - Unsigned mode: qneg = rneg = 0; ov never set.
- Output stability: out_valid, quotient, remainder, flags and out_tag stay stable while out_valid && !out_ready.
- Simultaneous accept and emit in the same cycle is legal and loses no data.
- in_valid=0 while adv=1 inserts a bubble into stage 0.

Test Plan (XWIDTH=8, DWIDTH=3, TAGW=4):
- Unsigned: X=200, D=3, tag=5, out_ready held 1 → after exactly 8 cycles: out_valid=1, Q=66, R=2, tag=5, flags 0. Also X=255, D=1 → Q=255, R=0.
- Signed: X=-7 (0xF9), D=2 → Q=0xFD (-3), R=3'b111 (-1). X=7, D=-4 (3'b100) → Q=0xFF (-1), R=3.
- Corner cases: X=100, D=0 (unsigned) → Q=0xFF, R=4, div_zero=1. Signed X=0x80, D=3'b111 → Q=0x80, R=0, overflow=1, div_zero=0.
- Backpressure:
  - Stream 12 back-to-back operations.
  - Drop out_ready for 5 cycles once out_valid=1 → in_ready=0 and outputs frozen for those 5 cycles.
  - Raise out_ready → all 12 results emerge in order with correct tags and no duplicates or losses.
- Bubbles: alternate in_valid 1/0 with random out_ready → results in order, out_valid pattern matches accepted operations, each result's latency equals 8 plus the number of stall cycles.
- Reset mid-stream: assert reset for 1 cycle with 6 operations in flight → out_valid=0 immediately, none of the 6 results ever appear; a new operation accepted afterwards returns after 8 cycles.
